// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - core/loader arbiter for a shared single-port data RAM
// Core has priority; a starvation counter forces one loader grant and stalls the core that cycle.
module dmem_port_arbiter #(
  parameter int data_width = 32,
  parameter int addr_width = 10,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CLEAR,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [addr_width-1:0] daddr,
  input  logic [data_width-1:0] ddata_w,
  output logic [data_width-1:0] ddata_r,
  output logic                  core_rvalid,
  output logic                  core_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [addr_width-1:0] ld_addr,
  input  logic [data_width-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic [data_width-1:0] ld_rdata,
  output logic                  ld_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic { ARB_CORE, ARB_LOADER } arb_state_e;
  typedef enum logic [1:0] { RD_NONE, RD_CORE, RD_LD } rd_owner_e;

  arb_state_e    state_q, state_d, arb_state;
  rd_owner_e     rd_owner_q, rd_owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic          active, core_req, core_gnt, ld_gnt_w;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ARB_CORE;
      rd_owner_q <= RD_NONE;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  // The forced loader grant is entered combinationally in the cycle the count saturates.
  always_comb begin
    active    = RESET_N & ~CLEAR;
    core_req  = MemRead | MemWrite;
    arb_state = state_q;
    if (state_q == ARB_CORE && ld_req && core_req && starve_q == CW'(MAX_WAIT))
      arb_state = ARB_LOADER;
    state_d   = ARB_CORE;
    core_gnt  = 1'b0;
    ld_gnt_w  = 1'b0;
    if (active) begin
      if (arb_state == ARB_LOADER) ld_gnt_w = 1'b1;
      else if (core_req)           core_gnt = 1'b1;
      else if (ld_req)             ld_gnt_w = 1'b1;
    end
  end

  always_comb begin
    mem_en    = core_gnt | ld_gnt_w;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = MemWrite;
      mem_addr  = daddr;
      mem_wdata = MemWrite ? ddata_w : '0;
    end else if (ld_gnt_w) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_we ? ld_wdata : '0;
    end
    ld_gnt     = ld_gnt_w;
    core_stall = ld_gnt_w & core_req;
  end

  always_comb begin
    starve_d = '0;
    if (active && ld_req && !ld_gnt_w)
      starve_d = (starve_q == CW'(MAX_WAIT)) ? starve_q : starve_q + CW'(1);
    rd_owner_d = RD_NONE;
    if (core_gnt && !MemWrite)   rd_owner_d = RD_CORE;
    else if (ld_gnt_w && !ld_we) rd_owner_d = RD_LD;
    err_d = active & (err_q | (MemRead & MemWrite));
  end

  // Read data is steered to exactly one requester; a CLEAR cycle drops it.
  always_comb begin
    core_rvalid = active && rd_owner_q == RD_CORE;
    ld_rvalid   = active && rd_owner_q == RD_LD;
    ddata_r     = core_rvalid ? mem_rdata : '0;
    ld_rdata    = ld_rvalid ? mem_rdata : '0;
    err         = err_q & active;
  end

endmodule
